md_unit_param: RTL and testbench

//   Parametrised multi-cycle multiply/divide unit with HI/LO registers. Lives in the E stage.

---
 rtl/md_unit_param_if.sv | 24 ++
 rtl/md_unit_param.sv | 162 ++++++++++++++++
 tb/tb_md_unit_param.sv | 221 ++++++++++++++++++++++
 3 files changed

// File: rtl/md_unit_param_if.sv
// Request/result bundle between the E-stage issue logic and the multiply/divide unit.
interface md_unit_param_if #(
   parameter int WIDTH = 32
);
   logic             start;
   logic [3:0]       op;
   logic [WIDTH-1:0] rs_val;
   logic [WIDTH-1:0] rt_val;
   logic             flush;
   logic             busy;
   logic             done;
   logic [WIDTH-1:0] hi;
   logic [WIDTH-1:0] lo;

   modport master (
      output start, op, rs_val, rt_val, flush,
      input  busy, done, hi, lo
   );

   modport slave (
      input  start, op, rs_val, rt_val, flush,
      output busy, done, hi, lo
   );
endinterface

// File: rtl/md_unit_param.sv
// Multi-cycle multiply/divide unit with HI/LO: result computed from latched operands,
// committed when the down-counter reaches terminal count.
//   state  | meaning
//   S_IDLE | no op in flight; MTHI/MTLO and new multi-cycle ops accepted
//   S_BUSY | op in flight; counter runs down to 0, then HI/LO commit
module md_unit_param #(
   parameter int WIDTH       = 32,
   parameter int MULT_CYCLES = 5,
   parameter int DIV_CYCLES  = 10
) (
   input logic          clk,
   input logic          reset,
   md_unit_param_if.slave md
);
   localparam int MAX_CYC = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
   localparam int CW      = $clog2(MAX_CYC + 1);
   localparam logic [CW-1:0] MULT_LOAD = CW'(MULT_CYCLES - 1);
   localparam logic [CW-1:0] DIV_LOAD  = CW'(DIV_CYCLES - 1);
   localparam logic [CW-1:0] CNT_ONE   = CW'(1);

   localparam logic [3:0] OP_MULT  = 4'd1;
   localparam logic [3:0] OP_MULTU = 4'd2;
   localparam logic [3:0] OP_DIV   = 4'd3;
   localparam logic [3:0] OP_DIVU  = 4'd4;
   localparam logic [3:0] OP_MADD  = 4'd5;
   localparam logic [3:0] OP_MADDU = 4'd6;
   localparam logic [3:0] OP_MSUB  = 4'd7;
   localparam logic [3:0] OP_MSUBU = 4'd8;
   localparam logic [3:0] OP_MTHI  = 4'd9;
   localparam logic [3:0] OP_MTLO  = 4'd10;

   typedef enum logic {S_IDLE, S_BUSY} state_t;

   state_t             r_state;
   state_t             w_state_nxt;
   logic [CW-1:0]      r_cnt;
   logic [3:0]         r_op;
   logic [WIDTH-1:0]   r_a;
   logic [WIDTH-1:0]   r_b;
   logic [WIDTH-1:0]   r_hi;
   logic [WIDTH-1:0]   r_lo;
   logic               r_done;

   logic               w_accept;
   logic               w_launch;
   logic               w_launch_div;
   logic               w_mt_hi;
   logic               w_mt_lo;
   logic               w_commit;

   logic               w_signed;
   logic [2*WIDTH-1:0] w_a_ext;
   logic [2*WIDTH-1:0] w_b_ext;
   logic [2*WIDTH-1:0] w_prod;
   logic [2*WIDTH-1:0] w_acc;
   logic               w_a_neg;
   logic               w_b_neg;
   logic [WIDTH-1:0]   w_a_mag;
   logic [WIDTH-1:0]   w_b_mag;
   logic [WIDTH-1:0]   w_q_mag;
   logic [WIDTH-1:0]   w_r_mag;
   logic [WIDTH-1:0]   w_quot;
   logic [WIDTH-1:0]   w_rem;
   logic [2*WIDTH-1:0] w_res;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) r_state <= S_IDLE;
      else        r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         S_IDLE: if (w_launch) w_state_nxt = S_BUSY;
         S_BUSY: if (md.flush || r_cnt == '0) w_state_nxt = S_IDLE;
         default: w_state_nxt = S_IDLE;
      endcase
   end

   // Flush wins over start in the same cycle, including the single-cycle moves.
   always_comb begin
      w_accept     = (r_state == S_IDLE) && md.start && !md.flush;
      w_launch     = w_accept && (md.op >= OP_MULT) && (md.op <= OP_MSUBU);
      w_launch_div = (md.op == OP_DIV) || (md.op == OP_DIVU);
      w_mt_hi      = w_accept && (md.op == OP_MTHI);
      w_mt_lo      = w_accept && (md.op == OP_MTLO);
      w_commit     = (r_state == S_BUSY) && !md.flush && (r_cnt == '0);
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_cnt <= '0;
         r_op  <= '0;
         r_a   <= '0;
         r_b   <= '0;
      end else if (w_launch) begin
         r_cnt <= w_launch_div ? DIV_LOAD : MULT_LOAD;
         r_op  <= md.op;
         r_a   <= md.rs_val;
         r_b   <= md.rt_val;
      end else if (r_state == S_BUSY) begin
         r_cnt <= (md.flush || r_cnt == '0) ? '0 : r_cnt - CNT_ONE;
      end
   end

   always_comb begin
      w_signed = (r_op == OP_MULT) || (r_op == OP_DIV) || (r_op == OP_MADD) || (r_op == OP_MSUB);
      w_a_ext  = w_signed ? {{WIDTH{r_a[WIDTH-1]}}, r_a} : {{WIDTH{1'b0}}, r_a};
      w_b_ext  = w_signed ? {{WIDTH{r_b[WIDTH-1]}}, r_b} : {{WIDTH{1'b0}}, r_b};
      w_prod   = w_a_ext * w_b_ext;
      w_acc    = {r_hi, r_lo};
   end

   // Divide on magnitudes, then restore signs; MIN/-1 wraps back to MIN naturally.
   always_comb begin
      w_a_neg = w_signed && r_a[WIDTH-1];
      w_b_neg = w_signed && r_b[WIDTH-1];
      w_a_mag = w_a_neg ? -r_a : r_a;
      w_b_mag = w_b_neg ? -r_b : r_b;
      w_q_mag = '0;
      w_r_mag = '0;
      w_quot  = '1;
      w_rem   = r_a;
      if (r_b != '0) begin
         w_q_mag = w_a_mag / w_b_mag;
         w_r_mag = w_a_mag % w_b_mag;
         w_quot  = (w_a_neg ^ w_b_neg) ? -w_q_mag : w_q_mag;
         w_rem   = w_a_neg ? -w_r_mag : w_r_mag;
      end
   end

   always_comb begin
      w_res = w_prod;
      case (r_op)
         OP_DIV, OP_DIVU:   w_res = {w_rem, w_quot};
         OP_MADD, OP_MADDU: w_res = w_acc + w_prod;
         OP_MSUB, OP_MSUBU: w_res = w_acc - w_prod;
         default:           w_res = w_prod;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_hi   <= '0;
         r_lo   <= '0;
         r_done <= 1'b0;
      end else begin
         r_done <= w_commit;
         if (w_commit) begin
            {r_hi, r_lo} <= w_res;
         end else begin
            if (w_mt_hi) r_hi <= md.rs_val;
            if (w_mt_lo) r_lo <= md.rs_val;
         end
      end
   end

   assign md.busy = (r_state == S_BUSY);
   assign md.done = r_done;
   assign md.hi   = r_hi;
   assign md.lo   = r_lo;
endmodule

// File: tb/tb_md_unit_param.sv
// Directed bench for md_unit_param: vector table for arithmetic and latency,
// hand sequences for flush, mid-op reset and back-to-back issue.
module tb_md_unit_param;
   localparam int W  = 32;
   localparam int MC = 5;
   localparam int DC = 10;

   logic clk;
   logic reset;
   int   errors = 0;
   int   checks = 0;

   md_unit_param_if #(.WIDTH(W)) m ();

   md_unit_param #(.WIDTH(W), .MULT_CYCLES(MC), .DIV_CYCLES(DC)) dut (
      .clk   (clk),
      .reset (reset),
      .md    (m)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [3:0]  op;
      logic [31:0] a;
      logic [31:0] b;
      logic [31:0] ihi;
      logic [31:0] ilo;
      logic [31:0] ehi;
      logic [31:0] elo;
      int          cyc;
   } vec_t;

   vec_t vt[14];

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic launch(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
      @(negedge clk);
      m.start  = 1'b1;
      m.op     = op;
      m.rs_val = a;
      m.rt_val = b;
      @(posedge clk);
      #1;
      m.start  = 1'b0;
      m.op     = 4'd0;
   endtask

   // Counts busy samples starting at the sample just after the launch edge.
   task automatic wait_done(output int n);
      n = 0;
      while (m.busy && n < 100) begin
         n++;
         @(posedge clk);
         #1;
      end
   endtask

   task automatic mt(input logic [3:0] op, input logic [31:0] v);
      launch(op, v, 32'h0);
   endtask

   initial begin
      int n;
      logic [31:0] sv_hi, sv_lo;
      logic        saw_done;

      vt[0]  = '{4'd1, 32'hFFFF_FFFE, 32'd3,         32'h0, 32'h0,         32'hFFFF_FFFF, 32'hFFFF_FFFA, MC};
      vt[1]  = '{4'd2, 32'hFFFF_FFFE, 32'd3,         32'h0, 32'h0,         32'h0000_0002, 32'hFFFF_FFFA, MC};
      vt[2]  = '{4'd3, 32'hFFFF_FFF9, 32'd2,         32'h0, 32'h0,         32'hFFFF_FFFF, 32'hFFFF_FFFD, DC};
      vt[3]  = '{4'd4, 32'd7,         32'd0,         32'h0, 32'h0,         32'h0000_0007, 32'hFFFF_FFFF, DC};
      vt[4]  = '{4'd3, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0, 32'h0,         32'h0000_0000, 32'h8000_0000, DC};
      vt[5]  = '{4'd6, 32'hFFFF_FFFF, 32'd2,         32'h1, 32'h0,         32'h0000_0002, 32'hFFFF_FFFE, MC};
      vt[6]  = '{4'd7, 32'd1,         32'd1,         32'h2, 32'hFFFF_FFFE, 32'h0000_0002, 32'hFFFF_FFFD, MC};
      vt[7]  = '{4'd3, 32'd100,       32'hFFFF_FFF9, 32'h0, 32'h0,         32'h0000_0002, 32'hFFFF_FFF2, DC};
      vt[8]  = '{4'd4, 32'd100,       32'd7,         32'h0, 32'h0,         32'h0000_0002, 32'h0000_000E, DC};
      vt[9]  = '{4'd5, 32'hFFFF_FFFD, 32'd4,         32'h0, 32'h5,         32'hFFFF_FFFF, 32'hFFFF_FFF9, MC};
      vt[10] = '{4'd8, 32'd1,         32'd1,         32'h0, 32'h0,         32'hFFFF_FFFF, 32'hFFFF_FFFF, MC};
      vt[11] = '{4'd1, 32'h8000_0000, 32'h8000_0000, 32'h0, 32'h0,         32'h4000_0000, 32'h0000_0000, MC};
      vt[12] = '{4'd3, 32'hFFFF_FFF9, 32'd0,         32'h0, 32'h0,         32'hFFFF_FFF9, 32'hFFFF_FFFF, DC};
      vt[13] = '{4'd7, 32'hFFFF_FFFF, 32'd1,         32'h0, 32'h0,         32'h0000_0000, 32'h0000_0001, MC};

      reset    = 1'b0;
      m.start  = 1'b0;
      m.op     = 4'd0;
      m.rs_val = '0;
      m.rt_val = '0;
      m.flush  = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      chk("reset_busy", {63'd0, m.busy}, 64'd0);
      chk("reset_done", {63'd0, m.done}, 64'd0);
      chk("reset_hilo", {m.hi, m.lo}, 64'd0);
      @(negedge clk);
      reset = 1'b1;

      mt(4'd9, 32'h1234_5678);
      chk("mthi_hi", {32'd0, m.hi}, {32'd0, 32'h1234_5678});
      chk("mthi_busy", {63'd0, m.busy}, 64'd0);
      mt(4'd10, 32'h9ABC_DEF0);
      chk("mtlo_lo", {32'd0, m.lo}, {32'd0, 32'h9ABC_DEF0});
      chk("mtlo_hi_kept", {32'd0, m.hi}, {32'd0, 32'h1234_5678});

      for (int i = 0; i < 14; i++) begin
         mt(4'd9, vt[i].ihi);
         mt(4'd10, vt[i].ilo);
         launch(vt[i].op, vt[i].a, vt[i].b);
         m.rs_val = 32'h5A5A_5A5A;
         m.rt_val = 32'hA5A5_A5A5;
         wait_done(n);
         chk($sformatf("v%0d_cycles", i), 64'(n), 64'(vt[i].cyc));
         chk($sformatf("v%0d_done", i), {63'd0, m.done}, 64'd1);
         chk($sformatf("v%0d_hilo", i), {m.hi, m.lo}, {vt[i].ehi, vt[i].elo});
         @(posedge clk);
         #1;
         chk($sformatf("v%0d_done_drop", i), {63'd0, m.done}, 64'd0);
      end

      // Flush at busy cycle 4 of a DIV: no commit, no done.
      mt(4'd9, 32'h0000_AAAA);
      mt(4'd10, 32'h0000_5555);
      launch(4'd3, 32'd100, 32'd7);
      repeat (3) begin
         @(posedge clk);
         #1;
      end
      chk("flush_busy_before", {63'd0, m.busy}, 64'd1);
      @(negedge clk);
      m.flush = 1'b1;
      @(posedge clk);
      #1;
      chk("flush_busy_after", {63'd0, m.busy}, 64'd0);
      @(negedge clk);
      m.flush = 1'b0;
      saw_done = 1'b0;
      repeat (12) begin
         @(posedge clk);
         #1;
         if (m.done) saw_done = 1'b1;
      end
      chk("flush_no_done", {63'd0, saw_done}, 64'd0);
      chk("flush_hilo", {m.hi, m.lo}, {32'h0000_AAAA, 32'h0000_5555});

      // Flush together with start cancels both kinds of op.
      @(negedge clk);
      m.flush = 1'b1; m.start = 1'b1; m.op = 4'd9; m.rs_val = 32'hDEAD_BEEF;
      @(posedge clk);
      #1;
      chk("flush_mthi_hi", {32'd0, m.hi}, {32'd0, 32'h0000_AAAA});
      @(negedge clk);
      m.op = 4'd1;
      @(posedge clk);
      #1;
      chk("flush_mult_busy", {63'd0, m.busy}, 64'd0);
      m.flush = 1'b0; m.start = 1'b0; m.op = 4'd0;

      // Reset at busy cycle 3 of a MULT.
      launch(4'd1, 32'd6, 32'd7);
      repeat (2) begin
         @(posedge clk);
         #1;
      end
      reset = 1'b0;
      #1;
      chk("rst_mid_busy", {63'd0, m.busy}, 64'd0);
      chk("rst_mid_hilo", {m.hi, m.lo}, 64'd0);
      @(negedge clk);
      m.start = 1'b1; m.op = 4'd1; m.rs_val = 32'd3; m.rt_val = 32'd3;
      @(posedge clk);
      #1;
      chk("rst_low_start_busy", {63'd0, m.busy}, 64'd0);
      @(negedge clk);
      m.start = 1'b0; m.op = 4'd0;
      reset = 1'b1;
      @(posedge clk);
      #1;
      chk("rst_release_busy", {63'd0, m.busy}, 64'd0);
      chk("rst_release_hilo", {m.hi, m.lo}, 64'd0);

      // Back-to-back: MULT, stray DIV mid-busy, DIVU launched in the done cycle, stray MTHI.
      launch(4'd1, 32'd6, 32'd7);
      @(negedge clk);
      m.start = 1'b1; m.op = 4'd3; m.rs_val = 32'd99; m.rt_val = 32'd0;
      @(posedge clk);
      #1;
      m.start = 1'b0; m.op = 4'd0;
      wait_done(n);
      chk("b2b_mult_cycles", 64'(n + 1), 64'(MC));
      chk("b2b_mult_done", {63'd0, m.done}, 64'd1);
      chk("b2b_mult_hilo", {m.hi, m.lo}, {32'd0, 32'd42});
      launch(4'd4, 32'd100, 32'd7);
      chk("b2b_div_done_drop", {63'd0, m.done}, 64'd0);
      @(negedge clk);
      m.start = 1'b1; m.op = 4'd9; m.rs_val = 32'h0000_0BAD;
      @(posedge clk);
      #1;
      m.start = 1'b0; m.op = 4'd0;
      chk("b2b_stray_mthi", {32'd0, m.hi}, 64'd0);
      wait_done(n);
      chk("b2b_div_cycles", 64'(n + 1), 64'(DC));
      chk("b2b_div_done", {63'd0, m.done}, 64'd1);
      chk("b2b_div_hilo", {m.hi, m.lo}, {32'd2, 32'd14});
      repeat (3) begin
         @(posedge clk);
         #1;
      end
      chk("b2b_idle_busy", {63'd0, m.busy}, 64'd0);
      chk("b2b_idle_hilo", {m.hi, m.lo}, {32'd2, 32'd14});

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
